reset_rls_seq: RTL
==================

# reset_rls_seq

Reset release sequencer for the consumer side of a board or bench reset. It takes one raw asynchronous active-low reset and asserts NUM_OUT downstream resets at once. Release is synchronized to clk, held for a fixed time, then staged one output at a time. Used behind the bench reset source and inside the shell to bring up submodules in a fixed order; it also honours a synchronous soft-reset request.

## Interface
Parameters:
- SYNC_STAGES, 3 — synchronizer depth; legal values ≥ 2.
- HOLD_CYCLES, 16 — clk cycles between synchronized release and release of rst_out[0]; legal values ≥ 1.
- NUM_OUT, 4 — number of sequenced reset outputs; legal values ≥ 1.
- STEP_CYCLES, 8 — clk cycles between successive output releases; legal values ≥ 1.
- OUT_ACTIVE, 1 — asserted level of rst_out (0 = active-low, nonzero = active-high).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- soft_rst_req  input  1  synchronous soft-reset request, sampled on posedge clk.
- rst_out  output  NUM_OUT  sequenced resets; bit i is released before bit i+1.
- done  output  1  high once every rst_out bit is released.
- rst_cnt  output  16  number of accepted soft-reset requests, saturating.

## Operation
- rst_n low (async):
  - all rst_out = OUT_ACTIVE immediately, with no clk required.
  - done = 0, rst_cnt = 0, state = SYNC, synchronizer cleared.
- States are SYNC, HOLD, RELEASE and DONE.
  - SYNC: waits for the synchronized reset to go high, then moves to HOLD with the counter cleared.
  - HOLD: counts HOLD_CYCLES, releases rst_out[0], then moves to RELEASE with index = 1. If NUM_OUT = 1 it moves to DONE instead.
  - RELEASE: counts STEP_CYCLES, then releases rst_out[index]. It increments index; after index NUM_OUT-1 it goes to DONE.
  - DONE: done = 1. It stays here until rst_n is asserted or soft_rst_req is accepted.
- soft_rst_req is accepted in HOLD, RELEASE or DONE. It is ignored in SYNC, and also ignored while rst_n is low.
  - On acceptance all rst_out bits are reasserted, done = 0, the counter and index clear, and state goes to HOLD.
  - rst_cnt increments, saturating at 0xFFFF.
  - A request that coincides with a scheduled release wins: the release does not happen.
  - A request held high for several cycles restarts HOLD on every cycle it is high and counts every cycle.
- Released rst_out bits stay released until rst_n is asserted or a soft reset is accepted. Bits are never released out of order.
- Cycle counter width is $clog2(max(HOLD_CYCLES, STEP_CYCLES)+1).
- Illegal parameters cause an elaboration-time $fatal.

## Timing
- Let E1 be the first posedge clk after rst_n rises, with edges numbered E1, E2, … thereafter.
- The synchronized reset goes high at E_SYNC_STAGES.
- rst_out[0] deasserts at E(SYNC_STAGES+HOLD_CYCLES).
- rst_out[i] deasserts at E(SYNC_STAGES+HOLD_CYCLES+i·STEP_CYCLES).
- done rises at the same edge as the last release.
- All outputs are registered. Assertion caused by rst_n is asynchronous; everything else changes only on posedge clk.
- Soft reset sampled at edge Es:
  - rst_out reasserts and done falls after Es.
  - rst_out[i] releases at Es+HOLD_CYCLES+i·STEP_CYCLES.
- A rst_n low pulse shorter than one clk period must still assert all outputs and restart the full sequence from SYNC.

## Structure
- Package reset_seq_pkg holds:
  - the state enum typedef (SYNC, HOLD, RELEASE, DONE);
  - the RST_CNT_W = 16 constant;
  - a function computing the counter width.
- Sub-module reset_sync is an SYNC_STAGES-deep flop chain with asynchronous clear and synchronous release. It is instantiated once; the FSM, counters and output registers live in the top module.

## Test plan
- Defaults, rst_n released mid-cycle → rst_out[0..3] release at E19/E27/E35/E43, done rises at E43, rst_cnt = 0.
- soft_rst_req single pulse sampled at Es in DONE → all rst_out reasserted after Es, rst_out[0] released at Es+16, done at Es+40, rst_cnt = 1.
- soft_rst_req at E27 (the scheduled rst_out[1] release) → rst_out[1] stays asserted, rst_out[0] reasserts, rst_out[0] releases at E43.
- soft_rst_req held high 5 cycles starting in DONE → rst_cnt = 5; releases are counted from the last high edge.
- rst_n low for 0.3 clk periods while in RELEASE → rst_out asserted with no clk edge, rst_cnt = 0, full E19..E43 sequence repeats.
- NUM_OUT=1, OUT_ACTIVE=0, soft_rst_req pulsed in SYNC → request ignored (rst_cnt = 0), rst_out goes 0→1 at E19, done at E19.

Source files
------------

// File: rtl/reset_rls_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package reset_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        SYNC,
        HOLD,
        RELEASE,
        DONE
    } state_e;

    // Width of the saturating soft-reset counter
    localparam int unsigned RST_CNT_W = 16;

    // Cycle counter width: wide enough to hold max(hold, step)
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned step_cycles);
        int unsigned m;
        m = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asynchronous clear, release shifted in over STAGES clocks.
module reset_sync #(
    parameter int unsigned STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    // Flop chain cleared asynchronously, fills with ones after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], 1'b1};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/reset_rls_seq.sv
// Reset release sequencer: synchronizes rst_n release, holds, then releases
// rst_out bits one at a time in index order. Soft reset restarts from HOLD.
module reset_rls_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned STEP_CYCLES = 8,
    parameter int          OUT_ACTIVE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soft_rst_req,
    output logic [NUM_OUT-1:0]   rst_out,
    output logic                 done,
    output logic [RST_CNT_W-1:0] rst_cnt
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
    localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic        ACT   = (OUT_ACTIVE != 0);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "reset_rls_seq: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "reset_rls_seq: HOLD_CYCLES must be >= 1");
    end
    if (NUM_OUT < 1) begin : g_bad_num
        $fatal(1, "reset_rls_seq: NUM_OUT must be >= 1");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
        $fatal(1, "reset_rls_seq: STEP_CYCLES must be >= 1");
    end

    logic w_sync;

    state_e                 r_state, w_state_d;
    logic [CNT_W-1:0]       r_cnt, w_cnt_d;
    logic [IDX_W-1:0]       r_idx, w_idx_d;
    logic [NUM_OUT-1:0]     r_rst_out, w_rst_out_d;
    logic                   r_done, w_done_d;
    logic [RST_CNT_W-1:0]   r_rst_cnt, w_rst_cnt_d;

    logic                   w_soft_ok;
    logic [CNT_W-1:0]       w_hold_cnt;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_sync (w_sync)
    );

    // The synchronized release edge itself is the first hold cycle, so the
    // SYNC exit performs a HOLD step with a zero count.
    assign w_hold_cnt = (r_state == HOLD) ? r_cnt : '0;
    assign w_soft_ok  = soft_rst_req && (r_state != SYNC);

    // Next-state: soft reset overrides any release scheduled for this edge
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_idx_d     = r_idx;
        w_rst_out_d = r_rst_out;
        w_done_d    = r_done;
        w_rst_cnt_d = r_rst_cnt;

        if (w_soft_ok) begin
            w_state_d   = HOLD;
            w_cnt_d     = '0;
            w_idx_d     = '0;
            w_rst_out_d = {NUM_OUT{ACT}};
            w_done_d    = 1'b0;
            if (r_rst_cnt != '1) begin
                w_rst_cnt_d = r_rst_cnt + RST_CNT_W'(1);
            end
        end else begin
            case (r_state)
                SYNC, HOLD: begin
                    if ((r_state == HOLD) || w_sync) begin
                        if (w_hold_cnt == HOLD_LAST) begin
                            w_rst_out_d[0] = ~ACT;
                            w_cnt_d        = '0;
                            w_idx_d        = IDX_W'(1);
                            if (NUM_OUT == 1) begin
                                w_state_d = DONE;
                                w_done_d  = 1'b1;
                            end else begin
                                w_state_d = RELEASE;
                            end
                        end else begin
                            w_cnt_d   = w_hold_cnt + CNT_W'(1);
                            w_state_d = HOLD;
                        end
                    end
                end
                RELEASE: begin
                    if (r_cnt == STEP_LAST) begin
                        w_rst_out_d[r_idx] = ~ACT;
                        w_cnt_d            = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_d = DONE;
                            w_done_d  = 1'b1;
                        end else begin
                            w_idx_d = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    w_done_d = 1'b1;
                end
                default: begin
                    w_state_d = SYNC;
                end
            endcase
        end
    end

    // State and output registers; rst_n assertion forces outputs immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SYNC;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= {NUM_OUT{ACT}};
            r_done    <= 1'b0;
            r_rst_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_idx     <= w_idx_d;
            r_rst_out <= w_rst_out_d;
            r_done    <= w_done_d;
            r_rst_cnt <= w_rst_cnt_d;
        end
    end

    assign rst_out = r_rst_out;
    assign done    = r_done;
    assign rst_cnt = r_rst_cnt;

endmodule
